// File: rtl/tick_pulse_gen.sv
// rtl/tick_pulse_gen.sv - multi-channel programmable tick/strobe generator with bounded cycle counter
module tick_pulse_gen #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic                    load,
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       toggle,
  output logic [CYC_W-1:0]        cycle_count,
  output logic                    done
);

  localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYCLES);

  logic [CYC_W-1:0] r_cyc;
  logic             r_done;

  // Global run counter: saturates at MAX_CYCLES and raises a sticky done, or free-runs when MAX_CYCLES is 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc  <= '0;
      r_done <= 1'b0;
    end else if (MAX_CYCLES == 0) begin
      r_cyc <= r_cyc + CYC_W'(1);
    end else if (r_cyc < MAX_C) begin
      r_cyc <= r_cyc + CYC_W'(1);
      if (r_cyc == MAX_C - CYC_W'(1)) begin
        r_done <= 1'b1;
      end
    end
  end

  assign cycle_count = r_cyc;
  assign done        = r_done;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             r_toggle;
    logic [CNT_W-1:0] w_per_eff;
    logic             w_wrap;

    // A programmed period of 0 is treated as 1 so the channel still ticks every enabled edge
    assign w_per_eff = (r_per == '0) ? CNT_W'(1) : r_per;
    assign w_wrap    = (r_cnt >= w_per_eff - CNT_W'(1));

    // Channel counter: load beats counting, done/disable freezes, wrap emits a tick
    always_ff @(posedge clk) begin
      if (rst) begin
        r_per    <= CNT_W'(1);
        r_cnt    <= '0;
        r_pulse  <= 1'b0;
        r_toggle <= 1'b0;
      end else if (load) begin
        r_per   <= period[g*CNT_W +: CNT_W];
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else if (r_done || !en[g]) begin
        r_pulse <= 1'b0;
      end else if (w_wrap) begin
        r_cnt    <= '0;
        r_pulse  <= 1'b1;
        r_toggle <= ~r_toggle;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_pulse <= 1'b0;
      end
    end

    assign pulse[g]  = r_pulse;
    assign toggle[g] = r_toggle;
  end

endmodule

// File: tb/tb_tick_pulse_gen.sv
// tb/tb_tick_pulse_gen.sv - randomized self-checking bench for tick_pulse_gen against a behavioural model
module tb_tick_pulse_gen;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               load;
  logic [NCH-1:0]     en;
  logic [NCH*CW-1:0]  period;

  logic [NCH-1:0] a_pulse, a_toggle, b_pulse, b_toggle;
  logic [15:0]    a_cyc;
  logic [3:0]     b_cyc;
  logic           a_done, b_done;

  tick_pulse_gen #(.NUM_CH(NCH), .CNT_W(CW), .CYC_W(16), .MAX_CYCLES(20)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .period(period), .load(load),
    .pulse(a_pulse), .toggle(a_toggle), .cycle_count(a_cyc), .done(a_done)
  );

  tick_pulse_gen #(.NUM_CH(NCH), .CNT_W(CW), .CYC_W(4), .MAX_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .period(period), .load(load),
    .pulse(b_pulse), .toggle(b_toggle), .cycle_count(b_cyc), .done(b_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: index 0 is the MAX_CYCLES=20 instance, index 1 the free-running one
  int max_c [2] = '{20, 0};
  int n_edges;
  int per_in [NCH];
  int per_q  [2][NCH];
  int en_cnt [2][NCH];
  bit m_pulse[2][NCH];
  bit m_tog  [2][NCH];

  function automatic bit model_done(int k);
    return (max_c[k] > 0) && (n_edges >= max_c[k]);
  endfunction

  task automatic model_edge();
    bit frozen [2];
    for (int k = 0; k < 2; k++) frozen[k] = model_done(k);
    if (rst) begin
      n_edges = 0;
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < NCH; c++) begin
          per_q[k][c] = 1; en_cnt[k][c] = 0; m_pulse[k][c] = 0; m_tog[k][c] = 0;
        end
    end else begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < NCH; c++) begin
          if (load) begin
            per_q[k][c] = per_in[c]; en_cnt[k][c] = 0; m_pulse[k][c] = 0;
          end else if (frozen[k] || !en[c]) begin
            m_pulse[k][c] = 0;
          end else begin
            int p;
            p = (per_q[k][c] == 0) ? 1 : per_q[k][c];
            en_cnt[k][c]++;
            if (en_cnt[k][c] % p == 0) begin
              m_pulse[k][c] = 1; m_tog[k][c] = ~m_tog[k][c];
            end else begin
              m_pulse[k][c] = 0;
            end
          end
        end
      n_edges++;
    end
  endtask

  task automatic compare_all();
    int exp_a_cyc;
    exp_a_cyc = (n_edges < 20) ? n_edges : 20;
    check_eq("a_cycle_count", 32'(a_cyc), 32'(exp_a_cyc));
    check_eq("a_done", 32'(a_done), 32'(model_done(0)));
    check_eq("b_cycle_count", 32'(b_cyc), 32'(n_edges % 16));
    check_eq("b_done", 32'(b_done), 32'(0));
    for (int c = 0; c < NCH; c++) begin
      check_eq($sformatf("a_pulse%0d", c),  32'(a_pulse[c]),  32'(m_pulse[0][c]));
      check_eq($sformatf("a_toggle%0d", c), 32'(a_toggle[c]), 32'(m_tog[0][c]));
      check_eq($sformatf("b_pulse%0d", c),  32'(b_pulse[c]),  32'(m_pulse[1][c]));
      check_eq($sformatf("b_toggle%0d", c), 32'(b_toggle[c]), 32'(m_tog[1][c]));
    end
  endtask

  task automatic apply_periods();
    for (int c = 0; c < NCH; c++) period[c*CW +: CW] = CW'(per_in[c]);
  endtask

  task automatic step();
    apply_periods();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  initial begin
    n_edges = 0;
    rst = 1'b1; load = 1'b0; en = '1;
    for (int c = 0; c < NCH; c++) per_in[c] = 0;
    apply_periods();
    step();
    step();

    for (int ep = 0; ep < 14; ep++) begin
      int len;
      len = $urandom_range(26, 40);
      for (int cyc = 0; cyc < len; cyc++) begin
        rst  = ($urandom_range(0, 99) < 2);
        load = ($urandom_range(0, 99) < 12);
        for (int c = 0; c < NCH; c++) begin
          en[c] = ($urandom_range(0, 99) < 80);
          per_in[c] = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
        end
        step();
      end
      rst = 1'b1; load = 1'b0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
